nios_system_pio_edge_input: RTL and testbench

Parametrised Avalon-MM input PIO with edge capture and interrupt, for pushbuttons and switches on the Nios system bus.
- Each input bit passes through a synchroniser, then an optional per-bit debouncer, then an edge detector.
- Detected edges latch into a capture register; a maskable, level-sensitive IRQ is raised to the CPU.
- Register map follows the standard PIO layout so existing HAL-style drivers work unchanged.

---
 rtl/nios_system_pio_pkg.sv | 34 +++
 rtl/nios_system_pio_sync_debounce.sv | 77 +++++++
 rtl/nios_system_pio_edge_input.sv | 127 ++++++++++++
 tb/tb_nios_system_pio_edge_input.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_pio_pkg
//  Description : Shared constants and helpers for the edge-capturing input
//                PIO: register addresses, edge-type encodings and a clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package nios_system_pio_pkg;

    // Register map (word addresses on the Avalon-MM slave)
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // EDGE_TYPE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Ceiling log2; returns 0 for inputs 0 and 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios_system_pio_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_pio_sync_debounce
//  Description : Single-bit synchroniser followed by an optional debouncer.
//                The debounced output only follows the synchronised input
//                once it has disagreed for DEBOUNCE_CYCLES consecutive
//                cycles; DEBOUNCE_CYCLES=0 passes the synchroniser through.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                i_async  - asynchronous input bit
//                o_stable - debounced, synchronised bit (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_system_pio_sync_debounce
    import nios_system_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_stable
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_out;
    logic                   r_stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stable <= 1'b0;
                end else begin
                    r_stable <= w_sync_out;
                end
            end
        end else begin : g_debounce
            localparam int             c_cnt_w   = clog2(DEBOUNCE_CYCLES) + 1;
            localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
            localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

            logic [c_cnt_w-1:0] r_cnt;

            // The counter tracks how many consecutive cycles the input has
            // disagreed with the accepted value; any agreement restarts it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (w_sync_out == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_stable <= w_sync_out;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    endgenerate

    assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/nios_system_pio_edge_input.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_pio_edge_input
//  Description : Avalon-MM input PIO with per-bit synchroniser/debouncer,
//                edge detection, write-1-to-clear edge capture and a
//                maskable level interrupt.
//  Ports       : clk        - system clock
//                reset      - synchronous active-high reset
//                address    - register select (0 data, 1 rsvd, 2 mask, 3 edge)
//                chipselect - slave select
//                write      - write strobe, qualified by chipselect
//                writedata  - write data
//                in_port    - asynchronous external inputs
//                readdata   - registered read data (latency 1)
//                irq        - active-high interrupt request
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_system_pio_edge_input
    import nios_system_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [1:0]       address,
    input  wire logic             chipselect,
    input  wire logic             write,
    input  wire logic [31:0]      writedata,
    input  wire logic [WIDTH-1:0] in_port,
    output logic      [31:0]      readdata,
    output logic                  irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;
    logic             w_wr;

    // Per-bit synchroniser + debouncer
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            nios_system_pio_sync_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_sync_debounce (
                .clk      (clk),
                .rst      (reset),
                .i_async  (in_port[gi]),
                .o_stable (w_stable[gi])
            );
        end
    endgenerate

    // Writedata bits above WIDTH have no destination.
    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    // Both the stable value and its delayed copy reset to zero, so leaving
    // reset with the inputs low never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    always_comb begin
        w_edge = w_stable & ~r_stable_d;
        case (EDGE_TYPE)
            EDGE_FALL: w_edge = ~w_stable & r_stable_d;
            EDGE_ANY:  w_edge = w_stable ^ r_stable_d;
            default:   w_edge = w_stable & ~r_stable_d;
        endcase
    end

    assign w_wr    = chipselect & write;
    assign w_clear = (w_wr && (address == PIO_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_wr && (address == PIO_ADDR_MASK)) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // Set is applied after clear so a coincident detect keeps the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clear) | w_edge;
        end
    end

    // Read mux is registered every cycle independent of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            case (address)
                PIO_ADDR_DATA: r_readdata <= 32'(w_stable);
                PIO_ADDR_DIR:  r_readdata <= '0;
                PIO_ADDR_MASK: r_readdata <= 32'(r_mask);
                PIO_ADDR_EDGE: r_readdata <= 32'(r_edgecap);
                default:       r_readdata <= '0;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_nios_system_pio_edge_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_system_pio_edge_input
//  Description : Self-checking bench for the edge-capturing input PIO.
//                Three instances share the bus: rising (default), falling
//                and any-edge variants, each with its own input port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_system_pio_edge_input;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port0, in_port_f, in_port_a;
    logic [31:0] rd0, rd_f, rd_a;
    logic        irq0, irq_f, irq_a;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_system_pio_edge_input #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in_port0), .readdata(rd0), .irq(irq0));

    nios_system_pio_edge_input #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in_port_f), .readdata(rd_f), .irq(irq_f));

    nios_system_pio_edge_input #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in_port_a), .readdata(rd_a), .irq(irq_a));

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic do_read(input logic [1:0] a);
        chipselect = 1'b1; write = 1'b0; address = a;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write = 1'b0; writedata = '0;
        in_port0 = '0; in_port_f = '0; in_port_a = '0;

        // Register-map vectors: readdata reflects register state before the edge.
        vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0, 1'b0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h0, 1'b0};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
        vecs[4]  = '{1'b1, 2'd2, 32'hFFFF_FFF5, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,         32'h5, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 32'hF,         32'h0, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, 32'hF,         32'h0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 32'h0,         32'h0, 1'b0};
        vecs[9]  = '{1'b0, 2'd1, 32'h0,         32'h0, 1'b0};
        vecs[10] = '{1'b1, 2'd2, 32'hF,         32'h5, 1'b0};
        vecs[11] = '{1'b0, 2'd2, 32'h0,         32'hF, 1'b0};
        vecs[12] = '{1'b1, 2'd3, 32'hF,         32'h0, 1'b0};
        vecs[13] = '{1'b0, 2'd3, 32'h0,         32'h0, 1'b0};

        // 1. Reset state and register map
        apply_reset();
        check("reset_irq", 32'(irq0), 32'h0);
        for (int i = 0; i < 14; i++) begin
            chipselect = 1'b1; write = vecs[i].wr; address = vecs[i].addr; writedata = vecs[i].wdata;
            tick();
            check($sformatf("regmap_rd[%0d]", i), rd0, vecs[i].exp_rd);
            check($sformatf("regmap_irq[%0d]", i), 32'(irq0), 32'(vecs[i].exp_irq));
        end
        chipselect = 1'b0; write = 1'b0; writedata = '0;

        // 2. Held input: stable after 6 edges, visible on read and irq at edge 7
        chipselect = 1'b1; address = 2'd0;
        in_port0 = 4'h1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("hold_data_k%0d", k), rd0, (k >= 7) ? 32'h1 : 32'h0);
            check($sformatf("hold_irq_k%0d", k), 32'(irq0), (k >= 7) ? 32'h1 : 32'h0);
        end
        do_read(2'd3);
        check("hold_edgecap", rd0, 32'h1);

        // 3. Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
        do_write(2'd3, 32'hF);
        check("glitch_pre_irq", 32'(irq0), 32'h0);
        chipselect = 1'b1; address = 2'd0;
        in_port0 = 4'h5;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) in_port0 = 4'h1;
            check($sformatf("p3_data_k%0d", k), rd0, 32'h1);
            check($sformatf("p3_irq_k%0d", k), 32'(irq0), 32'h0);
        end
        do_read(2'd3);
        check("p3_edgecap", rd0, 32'h0);
        chipselect = 1'b1; address = 2'd0;
        in_port0 = 4'h5;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) in_port0 = 4'h1;
            check($sformatf("p4_data_k%0d", k), rd0, (k >= 7 && k <= 10) ? 32'h5 : 32'h1);
            check($sformatf("p4_irq_k%0d", k), 32'(irq0), (k >= 7) ? 32'h1 : 32'h0);
        end
        do_read(2'd3);
        check("p4_edgecap", rd0, 32'h4);

        // 4. W1C with mask, then set-wins on a coincident detect and clear
        in_port0 = 4'h0;
        wait_cycles(12);
        in_port0 = 4'h1;
        wait_cycles(12);
        do_write(2'd2, 32'h4);
        do_read(2'd3);
        check("w1c_pre_edgecap", rd0, 32'h5);
        check("w1c_pre_irq", 32'(irq0), 32'h1);
        do_write(2'd3, 32'h4);
        check("w1c_irq_drop", 32'(irq0), 32'h0);
        do_read(2'd3);
        check("w1c_edgecap", rd0, 32'h1);
        do_write(2'd3, 32'h1);
        do_read(2'd3);
        check("w1c_bit0_clear", rd0, 32'h0);
        in_port0 = 4'h0;
        wait_cycles(12);
        in_port0 = 4'h1;
        wait_cycles(6);
        do_write(2'd3, 32'h1);
        do_read(2'd3);
        check("set_wins", rd0, 32'h1);
        do_write(2'd3, 32'h1);
        do_read(2'd3);
        check("clear_after_set_wins", rd0, 32'h0);

        // 5. Falling-edge and any-edge variants
        apply_reset();
        in_port_f = 4'hF;
        wait_cycles(12);
        do_read(2'd3);
        check("fall_ignores_rise", rd_f, 32'h0);
        in_port_f = 4'h0;
        wait_cycles(12);
        do_read(2'd3);
        check("fall_capture", rd_f, 32'hF);
        in_port_a = 4'h8;
        wait_cycles(12);
        do_read(2'd3);
        check("any_first_toggle", rd_a, 32'h8);
        do_write(2'd3, 32'h8);
        do_read(2'd3);
        check("any_cleared", rd_a, 32'h0);
        in_port_a = 4'h0;
        wait_cycles(12);
        do_read(2'd3);
        check("any_second_toggle", rd_a, 32'h8);

        // 6. Reset mid-debounce with edges pending
        apply_reset();
        in_port0 = 4'hA;
        wait_cycles(12);
        do_write(2'd2, 32'hF);
        do_read(2'd3);
        check("rst6_pre_edgecap", rd0, 32'hA);
        check("rst6_pre_irq", 32'(irq0), 32'h1);
        in_port0 = 4'h0;
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        check("rst6_irq", 32'(irq0), 32'h0);
        for (int a = 0; a < 4; a++) begin
            do_read(2'(a));
            check($sformatf("rst6_read_a%0d", a), rd0, 32'h0);
        end
        wait_cycles(12);
        do_read(2'd0);
        check("rst6_late_data", rd0, 32'h0);
        do_read(2'd3);
        check("rst6_late_edgecap", rd0, 32'h0);
        check("rst6_late_irq", 32'(irq0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
